dvsdclaa_seq_1v8: RTL and testbench
===================================

DVSDCLAA_SEQ_1V8 -- requirements
Module: dvsdclaa_seq_1v8

Nibble-serial multi-word adder: runs a 4-bit carry-lookahead slice once per cycle with a registered carry, producing a 4*NIBBLES-bit sum.

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: operand set offered.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port A, input, 4*NIBBLES: addend A.
REQ-007 SHALL have port B, input, 4*NIBBLES: addend B.
REQ-008 SHALL have port Cin, input, 1: carry into nibble 0.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes result.
REQ-011 SHALL have port S, output, 4*NIBBLES: sum.
REQ-012 SHALL have port Cout, output, 1: carry out of the MSB nibble.
REQ-013 SHALL have port Ovf, output, 1: two's-complement signed overflow.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL accept when in_valid&&in_ready at an edge: latch A, B; carry register := Cin; nibble counter k := 0; next state RUN.
REQ-018 SHALL ignore A, B and Cin at every edge other than an accepting edge.
REQ-019 SHALL, per RUN edge, compute the 4-bit slice k with per-bit P=A^B, G=A&B, lookahead carries c1..c4 from the carry register; write sum nibble k into S[4k+3:4k]; carry register := c4; k := k+1.
REQ-020 SHALL transition RUN->DONE on the edge where k==NIBBLES-1; exactly NIBBLES RUN cycles per operation.
REQ-021 SHALL set out_valid high after edge T+NIBBLES, where T is the accepting edge.
REQ-022 SHALL drive Cout from the final carry register value in DONE.
REQ-023 SHALL drive Ovf = (A_msb==B_msb)&&(S_msb!=A_msb), using the latched operands, valid in DONE.
REQ-024 SHALL hold S, Cout, Ovf and out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-025 SHALL go DONE->IDLE on the edge where out_ready=1; no new accept in that same cycle (in_ready=0 in DONE).
REQ-026 SHALL keep S, Cout and Ovf at their last values in IDLE and RUN; only out_valid qualifies them.
REQ-027 SHALL ignore out_ready outside DONE, and in_valid outside IDLE.
REQ-028 SHALL carry wrap-around naturally: the sum is modulo 2^(4*NIBBLES); the excess carry appears only on Cout.
REQ-029 SHALL keep k width at ceil(log2(NIBBLES)); k SHALL never index beyond NIBBLES-1.

Reset
REQ-030 SHALL on rst=1, independent of clk, force state IDLE, k=0, carry register=0, S=0, Cout=0, Ovf=0, out_valid=0, busy=0; in_ready=1.
REQ-031 SHALL on reset asserted mid-RUN or mid-DONE abandon the operation; no partial result is ever presented with out_valid=1.
REQ-032 SHALL permit an accept on the first rising edge after rst deasserts.

Verification (NIBBLES=4)
REQ-033 SHALL cover: A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0, Ovf=0; out_valid rises exactly 4 edges after the accepting edge.
REQ-034 SHALL cover: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Ovf=0 (full carry ripple across all nibbles).
REQ-035 SHALL cover: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, Ovf=1; and A=0x8000, B=0x8000 -> S=0x0000, Cout=1, Ovf=1.
REQ-036 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> S/Cout/Ovf/out_valid unchanged; in_valid=1 with new operands meanwhile is not accepted (in_ready=0).
REQ-037 SHALL cover reset mid-RUN: rst pulsed after 2 RUN edges -> outputs immediately at reset values; next operation 0x0F0F+0x00F1, Cin=0 -> S=0x1000, Cout=0.
REQ-038 SHALL cover random back-to-back traffic (≥1000 ops, random in_valid/out_ready) checked against a 17-bit reference sum: one result per accepted operand set, in order.

Source files
------------

// File: rtl/dvsdclaa_seq_1v8.sv
// Nibble-serial multi-word adder.
// A 4-bit carry-lookahead slice processes one nibble per cycle.
// The carry between nibbles is held in a register.
// The result is presented with a valid/ready handshake.
module dvsdclaa_seq_1v8 #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   Cout,
    output logic                   Ovf,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q;

    logic          accept;
    logic          last;
    logic [KW+1:0] base;
    logic [3:0]    a_nib, b_nib, p, g, sum_nib;
    logic [4:0]    c;

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (k_q == KLAST);
    assign base   = {k_q, 2'b00};

    // Lookahead slice on the current nibble, seeded from the carry register.
    always_comb begin
        a_nib   = a_q[base +: 4];
        b_nib   = b_q[base +: 4];
        p       = a_nib ^ b_nib;
        g       = a_nib & b_nib;
        c[0]    = carry_q;
        c[1]    = g[0] | (p[0] & c[0]);
        c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
        c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_nib = p ^ c[3:0];
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Operand latch, per-nibble sum write-back, and final carry/overflow capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            S[base +: 4] <= sum_nib;
            carry_q      <= c[4];
            if (last) begin
                // Wrap k to 0 so it never points past the top nibble.
                k_q  <= '0;
                Cout <= c[4];
                Ovf  <= (a_q[W-1] == b_q[W-1]) && (sum_nib[3] != a_q[W-1]);
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dvsdclaa_seq_1v8.sv
// Self-checking bench for the nibble-serial adder (NIBBLES=4).
module tb_dvsdclaa_seq_1v8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        Ovf;
    logic        busy;

    dvsdclaa_seq_1v8 #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: 17-bit sum plus sign-based overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        exp_t e;
        t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.s    = t[15:0];
        e.cout = t[16];
        e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_S"}, 32'(S), 32'(e.s));
            chk({tag, "_Cout"}, 32'(Cout), 32'(e.cout));
            chk({tag, "_Ovf"}, 32'(Ovf), 32'(e.ovf));
        end
    endtask

    // Offer one operand set at the negedge, wait for the result and check latency.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input exp_t e, input string tag, input bit release_it);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'(~a); B = 16'($urandom); Cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        pop_check(tag);
        if (release_it) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_released"}, 32'({out_valid, in_ready}), 32'b01);
        end
    endtask

    vec_t vecs[7];

    initial begin
        exp_t        e;
        logic [15:0] s_hold;
        logic        c_hold;
        logic        o_hold;
        int          acc;
        int          cyc;
        int          stray;
        bit          nv;
        bit          nr;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0; B = 16'h0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_flags", 32'({Cout, Ovf, out_valid, busy, in_ready}), 32'b00001);
        rst = 1'b0;

        // Table vectors; the first is offered on the first edge after reset.
        for (int i = 0; i < 7; i++) begin
            e.s = vecs[i].s; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, e, $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: result held while new operands are offered and refused.
        run_op(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0), "bp", 1'b0);
        s_hold = S; c_hold = Cout; o_hold = Ovf;
        for (int i = 0; i < 5; i++) begin
            A = 16'($urandom); B = 16'($urandom); Cin = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold_S%0d", i), 32'(S), 32'(s_hold));
            chk($sformatf("bp_hold_co%0d", i), 32'({Cout, Ovf}), 32'({c_hold, o_hold}));
            chk($sformatf("bp_hs%0d", i), 32'({out_valid, in_ready, busy}), 32'b101);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_exit_idle", 32'({out_valid, in_ready, busy}), 32'b010);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_accept", 32'({in_ready, busy}), 32'b10);

        // Reset in the middle of RUN abandons the operation.
        A = 16'h1234; B = 16'h1111; Cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_S", 32'(S), 32'd0);
        chk("mid_rst_flags", 32'({Cout, Ovf, out_valid, busy, in_ready}), 32'b00001);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("mid_no_stray_valid", 32'(stray), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, model(16'h0F0F, 16'h00F1, 1'b0), "post_rst", 1'b1);

        // Random back-to-back traffic against the reference model.
        acc = 0; cyc = 0;
        while ((acc < 1000 || q.size() > 0 || out_valid) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            nv = ($urandom_range(0, 3) != 0) && (acc < 1000);
            nr = ($urandom_range(0, 3) != 0);
            if (out_valid && nr) pop_check("rnd");
            A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
            if (in_ready && nv) begin
                q.push_back(model(A, B, Cin));
                acc++;
            end
            in_valid = nv; out_ready = nr;
        end
        chk("rnd_done_in_budget", 32'(cyc < 60000), 32'd1);
        chk("rnd_accepted", 32'(acc), 32'd1000);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
